// File: rtl/urv_fetch_queue_pkg.sv
// Shared types and constants for the uRV fetch stage.
//   URV_NOP            canonical NOP encoding (addi x0, x0, 0)
//   URV_FETCH_CREDITS  max outstanding requests + queued words
//   fetch_entry_t      one queued instruction {ir, pc}
//   word_align()       clears the byte-offset bits of an address
package urv_fetch_queue_pkg;

  localparam logic [31:0] URV_NOP           = 32'h0000_0013;
  localparam int unsigned URV_FETCH_CREDITS = 2;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/urv_fetch_queue_if.sv
// Fetch-stage bus bundle: execute redirect, decode handshake and
// instruction-memory port. Names keep the fetch stage's direction suffixes.
//   master: the fetch stage (drives im_addr_o/im_rd_o and f_*_o)
//   slave : the environment (decode, execute, instruction memory)
interface urv_fetch_queue_if;

  logic        f_stall_i;
  logic        x_bra_i;
  logic [31:0] x_pc_bra_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  modport master (
    input  f_stall_i, x_bra_i, x_pc_bra_i, im_data_i, im_valid_i,
    output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
  );

  modport slave (
    output f_stall_i, x_bra_i, x_pc_bra_i, im_data_i, im_valid_i,
    input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
  );

endinterface

// File: rtl/urv_fetch_fifo.sv
// Two-entry synchronous FIFO of {ir, pc} with a registered head.
//   clk_i, rst_i  clock, synchronous active-high reset (clears data too)
//   push_i/din_i  write an entry
//   pop_i         drop the head (ignored while empty)
//   flush_i       empty the FIFO; wins over push
//   head_o        registered head entry
//   valid_o       head is valid
//   count_o       occupancy 0..2
module urv_fetch_fifo
  import urv_fetch_queue_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign pop_ok = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) head_d = din_i;
          else                 tail_d = din_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = din_i;
          end else begin
            head_d = tail_q;
            tail_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_ok && count_q == 2'd2));

endmodule

// File: rtl/urv_fetch_queue.sv
// uRV instruction fetch stage: owns the PC, issues in-order word reads,
// queues returned words for decode and drops stale responses on redirect.
//   clk_i  core clock
//   rst_i  synchronous active-high reset (acts as a redirect to g_reset_vector)
//   bus    fetch bundle (master side): redirect, decode handshake, imem port
module urv_fetch_queue
  import urv_fetch_queue_pkg::*;
#(
  parameter logic [31:0] g_reset_vector = 32'h0000_0000,
  parameter int unsigned g_credits      = URV_FETCH_CREDITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  urv_fetch_queue_if.master bus
);

  localparam logic [31:0] RESET_PC = word_align(g_reset_vector);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   discard_q, discard_d;
  logic [31:0]  target;
  logic [1:0]   count;
  logic [2:0]   credits_used;
  logic         f_valid, pop, issue, push, kill;
  fetch_entry_t head;

  assign kill         = rst_i | bus.x_bra_i;
  assign pop          = f_valid & ~bus.f_stall_i;
  assign credits_used = {1'b0, outstanding_q} + {1'b0, count} - {2'b00, pop};
  assign issue        = ~kill & (credits_used < 3'(g_credits));
  assign push         = bus.im_valid_i & ~kill & (discard_q == '0);

  // Reset is folded into the redirect path and outstanding_q has no reset:
  // requests in flight across reset are still counted and their responses
  // dropped. Every response still in flight at a redirect is stale, so the
  // drop count is simply what remains in flight after this cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    target        = rst_i ? RESET_PC : word_align(bus.x_pc_bra_i);
    outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, bus.im_valid_i};
    if (kill) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      discard_d  = outstanding_q - {1'b0, bus.im_valid_i};
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      if (bus.im_valid_i && discard_q != '0) discard_d = discard_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    fetch_pc_q    <= fetch_pc_d;
    resp_pc_q     <= resp_pc_d;
    outstanding_q <= outstanding_d;
    discard_q     <= discard_d;
  end

  urv_fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.x_bra_i),
    .din_i   ('{ir: bus.im_data_i, pc: resp_pc_q}),
    .head_o  (head),
    .valid_o (f_valid),
    .count_o (count)
  );

  assign bus.im_rd_o   = issue;
  assign bus.im_addr_o = fetch_pc_q;
  assign bus.f_ir_o    = head.ir;
  assign bus.f_pc_o    = head.pc;
  assign bus.f_valid_o = f_valid;

  a_resp_expected: assert property (@(posedge clk_i)
    !(bus.im_valid_i && outstanding_q == '0));

endmodule
